shift_right_deserializer: RTL and testbench
===========================================

# shift_right_deserializer

Serial-in, parallel-out receiver for the MSB-first bit stream produced by the datapath's shift-left serializer. It collects `2*DATA_WIDTH` bits into a word and holds the completed word in an output register. The word is presented with a valid/ready handshake, so the next frame can be received while the consumer drains the previous word. Overrun detection is sticky. The block sits between the serial link and the word-wide datapath registers.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` from defines.v (8): half word width. Word width `WW = 2*DATA_WIDTH`.
- `CNT_W`, default `$clog2(2*DATA_WIDTH)+1`: width of the bit counter.
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous clear: aborts any partial frame and clears `q_valid` and `overrun`.
- `s_in`  in  1  serial data bit, MSB of the word first.
- `s_valid`  in  1  `s_in` is sampled on this edge when high.
- `q_ready`  in  1  consumer accepts `q_out` this cycle.
- `q_out`  out  `WW`  last completed word (registered).
- `q_valid`  out  1  `q_out` holds an unconsumed word.
- `busy`  out  1  a frame is partially received (state RECV).
- `bit_cnt`  out  `CNT_W`  number of bits in the current partial frame, 0..`WW-1`.
- `overrun`  out  1  sticky: a word completed while the previous word was unconsumed.

## Operation
- Internal shift register `sr[WW-1:0]`. On each accepted bit: `sr <= {sr[WW-2:0], s_in}`, so the first bit ends at the MSB.
- States:
  - IDLE: `bit_cnt == 0`.
  - RECV: `0 < bit_cnt < WW`.
- Transitions:
  - IDLE→RECV on the first `s_valid`.
  - RECV→RECV while bits accumulate.
  - RECV→IDLE on the edge that accepts bit `WW` (the frame completes).
  - When `WW == 1` is impossible (`DATA_WIDTH >= 1`), so at least 2 bits per frame.
- Completion: the `WW`-th accepted bit forms the word `{sr[WW-2:0], s_in}` and resets `bit_cnt` to 0.
- Output register, on a completion edge:
  - `q_valid == 0`, or `q_ready == 1` in the same cycle: `q_out <=` word, `q_valid <= 1`.
  - `q_valid == 1` and `q_ready == 0`: the word is dropped, `q_out` is unchanged, `overrun <= 1`.
- Handshake: with no completion, `q_valid && q_ready` clears `q_valid` and leaves `q_out` unchanged. `q_ready` while `q_valid == 0` has no effect.
- `clr` has priority over everything else. It sets `sr`, `bit_cnt` and `state` to 0/IDLE and clears `q_valid` and `overrun`; `q_out` is retained. A bit presented with `s_valid` in a `clr` cycle is discarded.
- `overrun` is cleared only by `clr` or reset.
- Gaps are allowed: `s_valid == 0` holds all receive state, with no timeout.

## Timing
- Reset values: `q_out = 0`, `q_valid = 0`, `busy = 0`, `bit_cnt = 0`, `overrun = 0`, `sr = 0`, state IDLE.
- Reset asserted mid-frame or mid-handshake returns all of the above immediately and asynchronously.
- Latency: `q_valid` and `q_out` update on the same edge that samples the last bit, and are visible the following cycle.
- Throughput: 1 bit per cycle sustained. Back-to-back frames need no idle cycle between them.
- Consumer timing: a consumer with `q_ready` tied high never causes overrun.
- Outputs `busy` and `bit_cnt` are registered and reflect the bits accepted so far.

## Test plan
All scenarios use `DATA_WIDTH = 8`.
- **Reset:** assert `reset_n = 0` mid-frame after 5 bits → all outputs 0 asynchronously; after release, 16 bits of 0xA5C3 → `q_out = 0xA5C3`, `q_valid = 1` one cycle after the 16th bit.
- **Gapped stream:** 0x8001 sent with `s_valid` toggling 1/0, `q_ready = 1` → `q_out = 0x8001`. `bit_cnt` steps 0..15 only on valid cycles and returns to 0.
- **Back-to-back:** 0x1234 then 0xFFFF with no gap, `q_ready` pulsed once after the first word → `q_out = 0x1234`, then 0xFFFF; `overrun = 0`.
- **Overrun:** 0x00FF then 0x5A5A with `q_ready = 0` throughout → `q_out` stays 0x00FF, `q_valid = 1`, `overrun = 1`.
- **Simultaneous ready and completion:** `q_ready = 1` on the same cycle the second word completes → `q_out = 0x5A5A`, `q_valid` stays 1, `overrun = 0`.
- **Clear:** `clr` after 7 bits, then a full 0xC0DE frame → `q_out = 0xC0DE`, not corrupted by the aborted bits. `clr` during overrun → `overrun = 0`, `q_valid = 0`, `q_out` retained.

Source files
------------

// File: rtl/shift_right_deserializer.sv
// Serial-in, parallel-out receiver for an MSB-first stream: collects 2*DATA_WIDTH bits
// per word and presents each finished word through a valid/ready output register.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module shift_right_deserializer #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_W      = $clog2(2*DATA_WIDTH)+1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    s_in,
  input  logic                    s_valid,
  input  logic                    q_ready,
  output logic [2*DATA_WIDTH-1:0] q_out,
  output logic                    q_valid,
  output logic                    busy,
  output logic [CNT_W-1:0]        bit_cnt,
  output logic                    overrun
);

  localparam int WW = 2*DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WW-1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state;
  // The word MSB would shift out on the completing edge, so only WW-1 bits are stored.
  logic [WW-2:0]   sr;
  logic [WW-1:0]   word;

  assign word = {sr, s_in};
  assign busy = (state == RECV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      q_out   <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (q_valid && q_ready)
        q_valid <= 1'b0;
      if (s_valid) begin
        sr <= (WW-1)'(word);
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          state   <= IDLE;
          if (!q_valid || q_ready) begin
            q_out   <= word;
            q_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          state   <= RECV;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_right_deserializer.sv
// Bench for shift_right_deserializer (DATA_WIDTH = 8): table-driven frames plus
// hand-written reset, back-to-back, overrun and clear sequences.
module tb_shift_right_deserializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr;
  logic        s_in;
  logic        s_valid;
  logic        q_ready;
  logic [15:0] q_out;
  logic        q_valid;
  logic        busy;
  logic [4:0]  bit_cnt;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];

  shift_right_deserializer #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .s_in    (s_in),
    .s_valid (s_valid),
    .q_ready (q_ready),
    .q_out   (q_out),
    .q_valid (q_valid),
    .busy    (busy),
    .bit_cnt (bit_cnt),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [15:0] rmask;
    bit          gap;
    logic [15:0] exp_q;
    bit          exp_ovr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // inputs are driven at the falling edge; outputs are sampled at the next falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int unsigned n,
                           input logic [15:0] rmask, input bit gap);
    for (int unsigned k = 1; k <= n; k++) begin
      s_valid = 1'b1;
      s_in    = w[16-k];
      q_ready = rmask[16-k];
      tick();
      check("bit_cnt", 32'(bit_cnt), k % 16);
      check("busy", 32'(busy), 32'((k % 16) != 0));
      if (gap) begin
        s_valid = 1'b0;
        q_ready = 1'b0;
        tick();
        check("bit_cnt_hold", 32'(bit_cnt), k % 16);
      end
    end
    s_valid = 1'b0;
    q_ready = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] rmask,
                           input bit gap, input logic [15:0] exp_word);
    logic [15:0] e;
    sb_q.push_back(exp_word);
    send_bits(w, 16, rmask, gap);
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = sb_q.pop_front();
      check("q_out", 32'(q_out), 32'(e));
      check("q_valid", 32'(q_valid), 1);
    end
  endtask

  task automatic drain();
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    check("q_valid_drained", 32'(q_valid), 0);
  endtask

  task automatic pulse_clr(input logic bit_in);
    clr     = 1'b1;
    s_valid = 1'b1;
    s_in    = bit_in;
    tick();
    clr     = 1'b0;
    s_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{word: 16'h8001, rmask: 16'hFFFF, gap: 1'b1, exp_q: 16'h8001, exp_ovr: 1'b0};
    vecs[1] = '{word: 16'h00FF, rmask: 16'h0000, gap: 1'b0, exp_q: 16'h00FF, exp_ovr: 1'b0};
    vecs[2] = '{word: 16'hA5A5, rmask: 16'h0001, gap: 1'b1, exp_q: 16'hA5A5, exp_ovr: 1'b0};
    vecs[3] = '{word: 16'h7E81, rmask: 16'h0000, gap: 1'b0, exp_q: 16'h7E81, exp_ovr: 1'b0};

    reset_n = 1'b0;
    clr     = 1'b0;
    s_in    = 1'b0;
    s_valid = 1'b0;
    q_ready = 1'b0;
    tick();
    tick();
    check("rst_q_out", 32'(q_out), 0);
    check("rst_q_valid", 32'(q_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_bit_cnt", 32'(bit_cnt), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset_n = 1'b1;
    tick();

    // reset mid-frame after 5 bits, observed before any further clock edge
    send_bits(16'hFFFF, 5, 16'h0000, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_bit_cnt", 32'(bit_cnt), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_q_valid", 32'(q_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    send_word(16'hA5C3, 16'h0000, 1'b0, 16'hA5C3);
    check("ovr_after_reset_frame", 32'(overrun), 0);

    for (int i = 0; i < 4; i++) begin
      drain();
      send_word(vecs[i].word, vecs[i].rmask, vecs[i].gap, vecs[i].exp_q);
      check("vec_overrun", 32'(overrun), 32'(vecs[i].exp_ovr));
      check("vec_bit_cnt_end", 32'(bit_cnt), 0);
    end

    // back-to-back frames, consumer accepts the first word during the second frame
    drain();
    send_word(16'h1234, 16'h0000, 1'b0, 16'h1234);
    send_word(16'hFFFF, 16'h8000, 1'b0, 16'hFFFF);
    check("b2b_overrun", 32'(overrun), 0);

    // overrun: second word dropped
    pulse_clr(1'b0);
    send_word(16'h00FF, 16'h0000, 1'b0, 16'h00FF);
    send_word(16'h5A5A, 16'h0000, 1'b0, 16'h00FF);
    check("ovr_set", 32'(overrun), 1);
    tick();
    check("ovr_sticky", 32'(overrun), 1);

    // clear during overrun keeps q_out
    pulse_clr(1'b1);
    check("clr_ovr", 32'(overrun), 0);
    check("clr_q_valid", 32'(q_valid), 0);
    check("clr_q_out_kept", 32'(q_out), 32'h00FF);

    // ready on the completing cycle replaces the pending word
    send_word(16'h00FF, 16'h0000, 1'b0, 16'h00FF);
    send_word(16'h5A5A, 16'h0001, 1'b0, 16'h5A5A);
    check("simul_overrun", 32'(overrun), 0);

    // clear mid-frame discards partial bits and the bit in the clear cycle
    drain();
    send_bits(16'hFFFF, 7, 16'h0000, 1'b0);
    pulse_clr(1'b1);
    check("clr_bit_cnt", 32'(bit_cnt), 0);
    check("clr_busy", 32'(busy), 0);
    send_word(16'hC0DE, 16'h0000, 1'b0, 16'hC0DE);
    check("clr_frame_overrun", 32'(overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
